// File: rtl/adv7513_config_seq.sv
// adv7513_config_seq: sequences ADV7513 register writes through the I2C master with retry, timeout and hot-plug re-run
module adv7513_config_seq #(
    parameter int NUM_WRITES     = 31,
    parameter int POWERUP_CYCLES = 10000000,
    parameter int MAX_RETRY      = 3,
    parameter int RETRY_GAP      = 50000,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int HPD_DEBOUNCE   = 1000000
) (
    input  logic       clk_50,
    input  logic       reset_al,
    input  logic       hdmi_int,
    input  logic       i2c_done,
    input  logic       i2c_fail,
    input  logic       i2c_byte_sel,
    output logic       i2c_start,
    output logic [7:0] byte_lut,
    output logic [4:0] write_idx,
    output logic       config_done,
    output logic       config_error,
    output logic [1:0] retry_count
);
    typedef enum logic [2:0] {PWRUP, ISSUE, WAIT, CHECK, GAP, DONE, ERROR} state_t;
    state_t state, state_n;
    logic [1:0] rst_sync, done_sync, fail_sync, sel_sync, int_sync;
    logic rst_n, done_d, done_rise, hpd, fail_lat, fail_n;
    logic start_n, cfg_done_n, cfg_err_n;
    logic [31:0] cnt, cnt_n;
    logic [4:0] idx_n;
    logic [1:0] retry_n;

    // reset synchroniser: assertion reaches all logic at once, release waits for two clk_50 edges
    always_ff @(posedge clk_50 or negedge reset_al)
        if (!reset_al) rst_sync <= 2'b00;
        else rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n = rst_sync[1];

    // two-flop synchronisers for the I2C-domain status and the hot-plug interrupt, plus done edge history
    always_ff @(posedge clk_50 or negedge rst_n)
        if (!rst_n) begin
            done_sync <= 2'b00;
            fail_sync <= 2'b00;
            sel_sync  <= 2'b00;
            int_sync  <= 2'b11;
            done_d    <= 1'b0;
        end else begin
            done_sync <= {done_sync[0], i2c_done};
            fail_sync <= {fail_sync[0], i2c_fail};
            sel_sync  <= {sel_sync[0], i2c_byte_sel};
            int_sync  <= {int_sync[0], hdmi_int};
            done_d    <= done_sync[1];
        end

    assign done_rise = done_sync[1] & ~done_d;
    assign hpd       = ~int_sync[1] && cnt == 32'(HPD_DEBOUNCE - 1);
    assign byte_lut  = {2'b00, write_idx, sel_sync[1] & (state == WAIT)};

    // sequencer state, shared cycle counter and outputs
    always_ff @(posedge clk_50 or negedge rst_n)
        if (!rst_n) begin
            state        <= PWRUP;
            cnt          <= '0;
            i2c_start    <= 1'b0;
            write_idx    <= '0;
            retry_count  <= '0;
            config_done  <= 1'b0;
            config_error <= 1'b0;
            fail_lat     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            i2c_start    <= start_n;
            write_idx    <= idx_n;
            retry_count  <= retry_n;
            config_done  <= cfg_done_n;
            config_error <= cfg_err_n;
            fail_lat     <= fail_n;
        end

    // next-state: one counter serves power-up, transfer timeout, retry gap and hot-plug debounce
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 32'd1;
        start_n    = i2c_start;
        idx_n      = write_idx;
        retry_n    = retry_count;
        cfg_done_n = config_done;
        cfg_err_n  = config_error;
        fail_n     = fail_lat;
        case (state)
            PWRUP: if (cnt == 32'(POWERUP_CYCLES - 1)) state_n = ISSUE;
            ISSUE: begin
                start_n = 1'b1;
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: if (done_rise || cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                start_n = 1'b0;
                fail_n  = done_rise ? fail_sync[1] : 1'b1;
                state_n = CHECK;
            end
            CHECK: begin
                cnt_n = '0;
                if (!fail_lat) begin
                    if (write_idx == 5'(NUM_WRITES - 1)) begin
                        cfg_done_n = 1'b1;
                        state_n    = DONE;
                    end else begin
                        idx_n   = write_idx + 5'd1;
                        retry_n = '0;
                        state_n = ISSUE;
                    end
                end else if (retry_count < 2'(MAX_RETRY)) begin
                    retry_n = retry_count + 2'd1;
                    state_n = GAP;
                end else begin
                    cfg_err_n = 1'b1;
                    state_n   = ERROR;
                end
            end
            GAP: if (cnt == 32'(RETRY_GAP - 1)) state_n = ISSUE;
            DONE, ERROR: begin
                cnt_n = int_sync[1] ? '0 : cnt + 32'd1;
                if (hpd) begin
                    cfg_done_n = 1'b0;
                    idx_n      = '0;
                    retry_n    = '0;
                    state_n    = ISSUE;
                end
            end
            default: state_n = PWRUP;
        endcase
    end
endmodule

// File: doc/adv7513_config_seq.md
Name: adv7513_config_seq

Overview:
- Sequences ADV7513 register initialisation over I2C.
- Sits directly upstream of the I2C master and the register look-up table: it selects the LUT byte index and drives the master's start/done handshake.
- Runs in the 50 MHz domain. It synchronises the slow I2C-domain status signals and retries failed writes.
- On a hot-plug interrupt it re-runs the whole sequence, then reports config complete or error to the video path.

Parameters:
NUM_WRITES, 31, number of two-byte register writes in the LUT (LUT byte indices 0..61)
POWERUP_CYCLES, 10000000, clk_50 cycles to wait after reset before the first write (200 ms)
MAX_RETRY, 3, retries allowed per write after a failed transfer
RETRY_GAP, 50000, clk_50 idle cycles between a fail and the retry (1 ms)
TIMEOUT_CYCLES, 5000000, clk_50 cycles allowed per transfer before it is treated as failed (100 ms)
HPD_DEBOUNCE, 1000000, clk_50 cycles hdmi_int must stay low before a re-run starts (20 ms)

Ports:
clk_50  in  1  system clock, 50 MHz
reset_al  in  1  asynchronous, active-low reset
hdmi_int  in  1  ADV7513 interrupt, active-low, asynchronous
i2c_done  in  1  I2C master transfer-complete level, I2C clock domain
i2c_fail  in  1  I2C master NACK flag, I2C clock domain, valid when i2c_done rises
i2c_byte_sel  in  1  I2C master data-byte select: 0 = register address byte, 1 = value byte
i2c_start  out  1  request to the I2C master, level, held until the transfer completes
byte_lut  out  8  LUT byte index = 2*write_idx + synchronised i2c_byte_sel
write_idx  out  5  index of the current write (0..NUM_WRITES-1)
config_done  out  1  high while all writes have succeeded
config_error  out  1  sticky; a write exhausted MAX_RETRY
retry_count  out  2  retries used on the current write

Behaviour:
- Reset: asynchronous assert, synchronous release. Reset values: i2c_start=0, byte_lut=0, write_idx=0, config_done=0, config_error=0, retry_count=0, state=PWRUP, all counters 0.
- Synchronisers: i2c_done, i2c_fail, i2c_byte_sel and hdmi_int each pass through 2 flops into clk_50. done_rise is detected on the synchronised i2c_done (registered copy, 0->1).
- PWRUP: count POWERUP_CYCLES, then go to ISSUE.
- ISSUE: assert i2c_start, clear the timeout counter, go to WAIT.
- WAIT:
  - Hold i2c_start=1.
  - byte_lut follows the synchronised i2c_byte_sel.
  - On done_rise: i2c_start<=0, then go to CHECK.
  - If the timeout counter reaches TIMEOUT_CYCLES-1: i2c_start<=0, treat as a fail.
- CHECK (uses i2c_fail sampled at done_rise):
  - Pass, write_idx==NUM_WRITES-1: go to DONE.
  - Pass, otherwise: write_idx+1, retry_count<=0, go to ISSUE.
  - Fail, retry_count<MAX_RETRY: retry_count+1, go to GAP.
  - Fail, retry_count==MAX_RETRY: config_error<=1, go to ERROR.
- GAP: i2c_start=0 for RETRY_GAP cycles, then go to ISSUE with the same write_idx.
- DONE: config_done=1, i2c_start=0.
  - A synchronised hdmi_int held low for HPD_DEBOUNCE consecutive cycles gives: config_done<=0, write_idx<=0, retry_count<=0, go to ISSUE.
  - Any high sample restarts the debounce count.
- ERROR: terminal until reset or a debounced hdmi_int. A debounced hdmi_int restarts as in DONE; config_error stays set until reset.
- i2c_start deasserts only after done_rise or timeout; it never pulses shorter than one full I2C transfer.
- done_rise outside WAIT is ignored.
- Latency: i2c_start rises 1 cycle after entering ISSUE. Completion is seen 3 clk_50 cycles after i2c_done rises (2 synchroniser flops + edge detect).
- byte_lut never exceeds 2*NUM_WRITES-1.
- No write_idx wrap: DONE is entered instead.
- Reset asserted mid-transfer: i2c_start drops immediately; on release the sequence restarts at PWRUP.

Test Plan:
- Nominal: POWERUP_CYCLES=100, the master model always passes -> 31 done_rises; write_idx steps 0..30; byte_lut shows 2n then 2n+1 per write; config_done=1 about 3 cycles after the 31st done.
- Single NACK on write 5 -> retry_count=1; i2c_start stays low for RETRY_GAP cycles; write 5 is reissued with byte_lut=10; the sequence completes with config_error=0.
- Write 7 NACKs 4 times -> retry_count reaches 3; config_error=1; state ERROR; i2c_start stays 0; write_idx=7.
- Master never raises done, TIMEOUT_CYCLES=200 -> i2c_start drops at cycle 200; retry_count=1; reissue follows after the gap.
- In DONE, hdmi_int low for HPD_DEBOUNCE-1 cycles -> no restart. Held low for the full HPD_DEBOUNCE -> config_done=0, write_idx=0, new transfer issued.
- reset_al pulsed low during WAIT on write 12 -> i2c_start=0 asynchronously; after release: PWRUP delay, then write 0.
